// File: rtl/cmp_pkg.sv
// Shared types for the SAR comparator controller: FSM states and the {gt,lt,eq} flag encoding.
// Pure declarations; no timing or flow control of its own.
package cmp_pkg;

  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;

  // Comparator flag vector, ordered {gt, lt, eq}
  typedef logic [2:0] flags_t;

  localparam flags_t GT = 3'b100;
  localparam flags_t LT = 3'b010;
  localparam flags_t EQ = 3'b001;

  function automatic logic flags_onehot(input flags_t f);
    return (f == GT) || (f == LT) || (f == EQ);
  endfunction

endpackage

// File: rtl/sar_compare_ctrl.sv
// SAR search of comparator operand A, MSB first; CMP_LAT cycles per bit, eq exits early.
// start is ignored while busy (no queueing); done is a one-cycle pulse with result held until next start.
module sar_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] WLOAD = 4'(CMP_LAT - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

  state_t        state;
  logic [IW-1:0] bit_idx;
  logic [3:0]    wcnt;
  flags_t        flags;

  logic [WIDTH-1:0] trial_upd;  // trial after deciding the current bit
  logic [WIDTH-1:0] trial_nxt;  // trial_upd with the next lower bit set

  assign flags = {cmp_gt, cmp_lt, cmp_eq};

  always_comb begin
    trial_upd = trial;
    if (flags == LT) trial_upd[bit_idx] = 1'b0;
    trial_nxt = trial_upd;
    if (bit_idx != '0) trial_nxt[bit_idx - IW'(1)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      trial   <= '0;
      bit_idx <= '0;
      wcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      exact   <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= TRY;
            trial   <= MSB_CODE;
            bit_idx <= IW'(WIDTH - 1);
            wcnt    <= WLOAD;
            busy    <= 1'b1;
            exact   <= 1'b0;
            err     <= 1'b0;
          end
        end
        TRY: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 4'd1;
          end else if (!flags_onehot(flags)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= trial;
            err    <= 1'b1;
            exact  <= 1'b0;
          end else if (flags == EQ) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= trial;
            exact  <= 1'b1;
          end else if (bit_idx == '0) begin
            state  <= DONE;
            done   <= 1'b1;
            trial  <= trial_upd;
            result <= trial_upd;
            exact  <= 1'b0;
          end else begin
            trial   <= trial_nxt;
            bit_idx <= bit_idx - IW'(1);
            wcnt    <= WLOAD;
          end
        end
        DONE: begin
          // Always drop to IDLE for at least one edge before the next accept
          state <= IDLE;
          busy  <= 1'b0;
          trial <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          trial <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_compare_ctrl.sv
// Scoreboard bench for sar_compare_ctrl against a behavioural comparator with a CMP_LAT-cycle flag delay.
module tb_sar_compare_ctrl;
  import cmp_pkg::*;

  localparam int W = 4;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_gt, cmp_lt, cmp_eq;
  logic [W-1:0] trial, result;
  logic         busy, done, exact, err;

  always #5 clk = ~clk;

  sar_compare_ctrl #(.WIDTH(W), .CMP_LAT(L)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .exact  (exact),
    .err    (err)
  );

  // Comparator model: one register stage on B, so flags settle CMP_LAT-1 edges after trial moves
  logic [W-1:0] a_val = '0;
  logic [W-1:0] trial_d = '0;
  logic         force_en = 1'b0;
  flags_t       force_val = '0;
  flags_t       mflags;

  always @(posedge clk) trial_d <= trial;

  always_comb begin
    mflags = {a_val > trial_d, a_val < trial_d, a_val == trial_d};
    if (force_en) mflags = force_val;
  end
  assign {cmp_gt, cmp_lt, cmp_eq} = mflags;

  typedef struct {
    logic [W-1:0] res;
    logic         ex;
    logic         er;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] trial_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  bit trial_chk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic ex, input logic er, input int lat);
    exp_t e;
    e.res = r; e.ex = ex; e.er = er; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Reference search: trial for bit k keeps A's bits above k and sets bit k; stop once it equals A
  task automatic push_model(input logic [W-1:0] a);
    int n = 0;
    for (int k = W - 1; k >= 0; k--) begin
      int t;
      t = (int'(a) & ~((1 << (k + 1)) - 1)) | (1 << k);
      trial_q.push_back(W'(t));
      n++;
      if (t == int'(a)) break;
    end
    push_exp(a, a != '0, 1'b0, n * L);
  endtask

  // Monitor
  initial begin
    logic         prev_busy = 1'b0;
    logic         prev_done = 1'b0;
    logic [W-1:0] last_trial = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0; prev_done = 1'b0; last_trial = '0;
      end else begin
        if (busy && !prev_busy) acc_cyc = cyc;
        if (prev_done) begin
          chk("idle_gap_busy", busy, 0);
          chk("idle_gap_done", done, 0);
        end
        if (trial_chk && busy && !done && trial != last_trial) begin
          if (trial_q.size() == 0) chk("unexpected_trial", trial, -1);
          else chk("trial", trial, trial_q.pop_front());
        end
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("exact", exact, e.ex);
            chk("err", err, e.er);
            chk("latency", cyc - acc_cyc, e.lat);
            chk("busy_in_done", busy, 1);
          end
        end
        prev_busy = busy; prev_done = done; last_trial = trial;
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", int'(done_cnt >= target), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_trial"}, trial, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_exact"}, exact, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  int nd = 0;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // A=5: eq on the last bit
    a_val = 4'd5;
    trial_q.push_back(4'b1000); trial_q.push_back(4'b0100);
    trial_q.push_back(4'b0110); trial_q.push_back(4'b0101);
    push_exp(4'b0101, 1'b1, 1'b0, 8);
    do_start(); nd++; wait_done(nd);

    // A=12: early eq on bit 2
    a_val = 4'd12;
    trial_q.push_back(4'b1000); trial_q.push_back(4'b1100);
    push_exp(4'b1100, 1'b1, 1'b0, 4);
    do_start(); nd++; wait_done(nd);

    // A=0: every trial lt, no eq ever
    a_val = 4'd0;
    trial_q.push_back(4'b1000); trial_q.push_back(4'b0100);
    trial_q.push_back(4'b0010); trial_q.push_back(4'b0001);
    push_exp(4'b0000, 1'b0, 1'b0, 8);
    do_start(); nd++; wait_done(nd);

    for (int i = 0; i < 16; i++) begin
      a_val = W'(i);
      push_model(W'(i));
      do_start(); nd++; wait_done(nd);
    end

    // Non-one-hot flags at the first sample edge
    force_en = 1'b1; force_val = 3'b110;
    trial_q.push_back(4'b1000);
    push_exp(4'b1000, 1'b0, 1'b1, 2);
    do_start(); nd++; wait_done(nd);
    force_en = 1'b0;
    @(negedge clk);
    chk("err_held_idle", err, 1);
    chk("result_held_idle", result, 8);

    a_val = 4'd3;
    push_model(4'd3);
    do_start(); nd++; wait_done(nd);

    // Reset mid-search
    trial_chk = 1'b0;
    a_val = 4'd9;
    do_start();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_hold");
    rst_n = 1'b1;
    trial_chk = 1'b1;
    trial_q.push_back(4'b1000); trial_q.push_back(4'b1100);
    trial_q.push_back(4'b1010); trial_q.push_back(4'b1001);
    push_exp(4'b1001, 1'b1, 1'b0, 8);
    do_start(); nd++; wait_done(nd);

    // start held high: three back-to-back searches
    a_val = 4'd7;
    for (int i = 0; i < 3; i++) push_model(4'd7);
    @(negedge clk); start = 1'b1;
    nd += 3;
    wait_done(nd);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_extra_done", done_cnt, nd);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("trial_q_empty", trial_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
